// File: rtl/rc5_pkg.sv
// rc5_pkg: shared RC5-16 parameters, types and engine state encoding
package rc5_pkg;
  localparam int W = 16;
  localparam int LGW = 4;
  localparam int MAX_ROUNDS = 12;
  localparam int T = 2 * (MAX_ROUNDS + 1);
  localparam logic [W-1:0] P = 16'hb7e1;
  localparam logic [W-1:0] Q = 16'h9e37;
  typedef logic [W-1:0] word_t;
  typedef logic [2*W-1:0] block_t;
  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_t;
endpackage

// File: rtl/rc5_rotr.sv
// rc5_rotr: combinational W-bit barrel rotate-right by an LGW-bit amount
module rc5_rotr import rc5_pkg::*; (
  input  logic [W-1:0]   x,
  input  logic [LGW-1:0] n,
  output logic [W-1:0]   y
);
  // a zero amount makes the left shift W wide, which yields 0 and keeps x intact
  assign y = (x >> n) | (x << ((LGW + 1)'(W) - {1'b0, n}));
endmodule

// File: rtl/rc5_decrypt.sv
// rc5_decrypt: iterative RC5-16/r/16 decryption, one full round per cycle
module rc5_decrypt import rc5_pkg::*; (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_ready,
  input  logic [W-1:0]     sub [0:T-1],
  input  logic [4:0]       num_rounds,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2*W-1:0]   ct,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*W-1:0]   pt,
  output logic             err
);
  state_t state, state_nx;
  word_t a, b, bd, ad, rb, ra, bn, an;
  logic [4:0] i;
  logic accept;
  assign accept = in_valid && in_ready;
  assign bd = b - sub[{i[3:0], 1'b1}];
  assign ad = a - sub[{i[3:0], 1'b0}];
  rc5_rotr u_rot_b (.x(bd), .n(a[LGW-1:0]), .y(rb));
  assign bn = rb ^ a;
  // A's half-round uses the freshly computed B
  rc5_rotr u_rot_a (.x(ad), .n(bn[LGW-1:0]), .y(ra));
  assign an = ra ^ bn;
  always_ff @(posedge clk) state <= rst ? IDLE : state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  state_nx = !accept ? IDLE : num_rounds > 5'(MAX_ROUNDS) ? DONE : num_rounds == 5'd0 ? FINAL : ROUND;
      ROUND: state_nx = !key_ready ? IDLE : i == 5'd1 ? FINAL : ROUND;
      FINAL: state_nx = key_ready ? DONE : IDLE;
      DONE:  state_nx = out_ready ? IDLE : DONE;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    in_ready = state == IDLE && key_ready && !rst;
    out_valid = state == DONE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      a <= '0;
      b <= '0;
      i <= '0;
      pt <= '0;
      err <= 1'b0;
    end else if (accept) begin
      a <= ct[W-1:0];
      b <= ct[2*W-1:W];
      i <= num_rounds;
      if (num_rounds > 5'(MAX_ROUNDS)) begin
        pt <= '0;
        err <= 1'b1;
      end
    end else if (state == ROUND && key_ready) begin
      a <= an;
      b <= bn;
      i <= i - 5'd1;
    end else if (state == FINAL && key_ready) begin
      pt <= {b - sub[1], a - sub[0]};
      err <= 1'b0;
    end
  end
endmodule

// File: tb/tb_rc5_decrypt.sv
// tb_rc5_decrypt: directed and model-driven checks of the RC5 decryption engine
module tb_rc5_decrypt;
  import rc5_pkg::*;
  logic clk = 0, rst = 1, key_ready = 0, in_valid = 0, out_ready = 0;
  logic [W-1:0] sk [0:T-1];
  logic [4:0] num_rounds = 0;
  block_t ct = 0, pt;
  logic in_ready, out_valid, err;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  rc5_decrypt dut (
    .clk(clk), .rst(rst), .key_ready(key_ready), .sub(sk), .num_rounds(num_rounds),
    .in_valid(in_valid), .in_ready(in_ready), .ct(ct), .out_valid(out_valid),
    .out_ready(out_ready), .pt(pt), .err(err)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic word_t rotl(input word_t x, input int n);
    int m;
    m = n & 15;
    if (m == 0) return x;
    return (x << m) | (x >> (16 - m));
  endfunction

  task automatic zero_keys;
    for (int k = 0; k < T; k++) sk[k] = '0;
  endtask

  // standard RC5 key expansion with a 16-byte key
  task automatic keygen(input logic [127:0] key);
    word_t l [8];
    word_t x, y;
    int ii, jj;
    x = 0; y = 0; ii = 0; jj = 0;
    for (int k = 0; k < 8; k++) l[k] = key[16*k +: 16];
    sk[0] = P;
    for (int k = 1; k < T; k++) sk[k] = sk[k-1] + Q;
    for (int k = 0; k < 3 * T; k++) begin
      x = rotl(sk[ii] + x + y, 3);
      sk[ii] = x;
      y = rotl(l[jj] + x + y, int'((x + y) & 16'hf));
      l[jj] = y;
      ii = (ii + 1) % T;
      jj = (jj + 1) % 8;
    end
  endtask

  function automatic block_t encrypt(input block_t p, input int r);
    word_t a, b;
    a = p[15:0] + sk[0];
    b = p[31:16] + sk[1];
    for (int k = 1; k <= r; k++) begin
      a = rotl(a ^ b, int'(b[3:0])) + sk[2*k];
      b = rotl(b ^ a, int'(a[3:0])) + sk[2*k+1];
    end
    return {b, a};
  endfunction

  task automatic run_block(input block_t c, input logic [4:0] r, output int lat, output block_t p, output logic e);
    int k;
    k = 0;
    while (in_ready !== 1'b1 && k < 20) begin tick; k++; end
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL accept_ready in_ready=%b want 1", in_ready); end
    ct = c; num_rounds = r; in_valid = 1;
    tick;
    in_valid = 0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 40) begin tick; lat++; end
    p = pt; e = err;
    out_ready = 1;
    tick;
    out_ready = 0;
  endtask

  task automatic test_reset;
    rst = 1; key_ready = 1;
    tick; tick;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b want 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want 0", out_valid); end
    checks++; if (pt !== 32'h0) begin failures++; $display("FAIL reset_pt got=%h want 0", pt); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b want 0", err); end
    rst = 0;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL release_in_ready got=%b want 1", in_ready); end
  endtask

  task automatic test_r0;
    int lat; block_t p; logic e;
    zero_keys;
    run_block(32'h1234_5678, 5'd0, lat, p, e);
    checks++; if (lat !== 2) begin failures++; $display("FAIL r0_latency got=%0d want 2", lat); end
    checks++; if (p !== 32'h1234_5678) begin failures++; $display("FAIL r0_pt got=%h want 12345678", p); end
    checks++; if (e !== 1'b0) begin failures++; $display("FAIL r0_err got=%b want 0", e); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL r0_release got=%b want 0", out_valid); end
    sk[0] = 16'h0001; sk[1] = 16'h0002;
    run_block(32'h0010_0005, 5'd0, lat, p, e);
    checks++; if (p !== 32'h000E_0004) begin failures++; $display("FAIL r0_keys_pt got=%h want 000e0004", p); end
  endtask

  task automatic test_r1;
    int lat; block_t p; logic e;
    zero_keys;
    run_block(32'h0000_0001, 5'd1, lat, p, e);
    checks++; if (lat !== 3) begin failures++; $display("FAIL r1_latency got=%0d want 3", lat); end
    checks++; if (p !== 32'h0001_8001) begin failures++; $display("FAIL r1_pt got=%h want 00018001", p); end
  endtask

  task automatic test_gate;
    key_ready = 0; in_valid = 1; ct = 32'hcafe_f00d; num_rounds = 5'd0;
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL gate_in_ready got=%b want 0", in_ready); end
    tick; tick; tick;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL gate_no_accept out_valid=%b want 0", out_valid); end
    in_valid = 0; key_ready = 1;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL gate_idle in_ready=%b want 1", in_ready); end
  endtask

  task automatic test_r12;
    int lat; block_t p; logic e;
    keygen(128'h0f1e_2d3c_4b5a_6978_8796_a5b4_c3d2_e1f0);
    run_block(encrypt(32'hdead_beef, 12), 5'd12, lat, p, e);
    checks++; if (lat !== 14) begin failures++; $display("FAIL r12_latency got=%0d want 14", lat); end
    checks++; if (p !== 32'hdead_beef) begin failures++; $display("FAIL r12_pt got=%h want deadbeef", p); end
    checks++; if (e !== 1'b0) begin failures++; $display("FAIL r12_err got=%b want 0", e); end
  endtask

  task automatic test_random;
    block_t p, held;
    logic [4:0] r;
    int lat, k, st;
    for (int n = 0; n < 500; n++) begin
      p = $urandom;
      r = 5'($urandom_range(0, 12));
      k = 0;
      while (in_ready !== 1'b1 && k < 20) begin tick; k++; end
      ct = encrypt(p, int'(r)); num_rounds = r; in_valid = 1;
      tick;
      in_valid = 0; ct = $urandom;
      lat = 1;
      while (out_valid !== 1'b1 && lat < 40) begin tick; lat++; end
      checks++; if (lat !== int'(r) + 2) begin failures++; $display("FAIL rand_latency blk=%0d got=%0d want %0d", n, lat, int'(r) + 2); end
      held = pt;
      st = $urandom_range(0, 3);
      for (int s = 0; s < st; s++) begin
        tick;
        checks++; if (out_valid !== 1'b1 || pt !== held) begin failures++; $display("FAIL rand_stall blk=%0d valid=%b pt=%h want 1 %h", n, out_valid, pt, held); end
      end
      checks++; if (pt !== p || err !== 1'b0) begin failures++; $display("FAIL rand_pt blk=%0d r=%0d got=%h err=%b want %h err=0", n, r, pt, err, p); end
      out_ready = 1;
      tick;
      out_ready = 0;
    end
  endtask

  task automatic test_err;
    int lat; block_t p; logic e;
    run_block(32'h5555_aaaa, 5'd13, lat, p, e);
    checks++; if (lat !== 1) begin failures++; $display("FAIL err_latency got=%0d want 1", lat); end
    checks++; if (e !== 1'b1) begin failures++; $display("FAIL err_flag got=%b want 1", e); end
    checks++; if (p !== 32'h0) begin failures++; $display("FAIL err_pt got=%h want 0", p); end
    run_block(encrypt(32'h0bad_f00d, 12), 5'd12, lat, p, e);
    checks++; if (p !== 32'h0bad_f00d || e !== 1'b0) begin failures++; $display("FAIL after_err got=%h err=%b want 0badf00d err=0", p, e); end
  endtask

  task automatic test_abort;
    logic seen;
    seen = 0;
    ct = encrypt(32'h1357_9bdf, 12); num_rounds = 5'd12; in_valid = 1;
    tick;
    in_valid = 0;
    repeat (4) tick;
    key_ready = 0;
    for (int k = 0; k < 20; k++) begin tick; if (out_valid === 1'b1) seen = 1; end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL abort_output seen=%b want 0", seen); end
    key_ready = 1;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL abort_idle in_ready=%b want 1", in_ready); end
  endtask

  task automatic test_rst_mid;
    int lat; block_t p; logic e;
    ct = encrypt(32'h2468_ace0, 12); num_rounds = 5'd12; in_valid = 1;
    tick;
    in_valid = 0;
    repeat (3) tick;
    rst = 1;
    tick;
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_hs in_ready=%b out_valid=%b want 0 0", in_ready, out_valid); end
    checks++; if (pt !== 32'h0 || err !== 1'b0) begin failures++; $display("FAIL rst_mid_out pt=%h err=%b want 0 0", pt, err); end
    rst = 0;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_mid_release in_ready=%b want 1", in_ready); end
    run_block(encrypt(32'h7777_0001, 5), 5'd5, lat, p, e);
    checks++; if (p !== 32'h7777_0001 || lat !== 7) begin failures++; $display("FAIL rst_mid_recover pt=%h lat=%0d want 77770001 7", p, lat); end
  endtask

  initial begin
    test_reset;
    test_r0;
    test_r1;
    test_gate;
    test_r12;
    test_random;
    test_err;
    test_abort;
    test_rst_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rc5_decrypt.md
Name: rc5_decrypt

Overview:
Iterative RC5-16/r/16 decryption engine that consumes the expanded subkey table S[0..T-1] produced by the key generator. It sits downstream of the key generator and accepts one 32-bit ciphertext block at a time. Each block is decrypted at one full round per cycle, then emitted through a valid/ready output handshake. Block accept is gated on the key generator's ready flag.

Parameters:
W, 16, word size in bits; block is 2*W.
MAX_ROUNDS, 12, largest supported round count.
T, 2*(MAX_ROUNDS+1) = 26, subkey table depth.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  reset, synchronous, active-high.
key_ready  in  1  subkey table valid; connected to the key generator's ready flag.
sub  in  T x W  subkey table S[0..T-1], an unpacked array indexed 0..T-1.
num_rounds  in  5  round count r, sampled on block accept.
in_valid  in  1  ciphertext block valid.
in_ready  out  1  engine can accept a block.
ct  in  2W  ciphertext; ct[W-1:0] is A, ct[2W-1:W] is B.
out_valid  out  1  plaintext valid.
out_ready  in  1  downstream accepts plaintext.
pt  out  2W  plaintext; same A/B packing as ct.
err  out  1  qualifies out_valid; 1 means r > MAX_ROUNDS and pt = 0.

Behaviour:
- Reset values: in_ready=0, out_valid=0, pt=0, err=0, state=IDLE. The round counter and A/B registers are cleared to 0.
- States: IDLE, ROUND, FINAL, DONE.
- in_ready = (state==IDLE) && key_ready && !rst.
- Accept occurs when in_valid && in_ready. On accept: A<=ct[15:0], B<=ct[31:16], i<=num_rounds.
  - If num_rounds > MAX_ROUNDS: go to DONE with err=1 and pt=0.
  - Else if num_rounds == 0: go to FINAL.
  - Else: go to ROUND.
- ROUND performs one full round per cycle, with B computed first and its new value used for A in the same cycle:
  - Bn = rotr(B - S[2i+1], A[3:0]) ^ A.
  - An = rotr(A - S[2i], Bn[3:0]) ^ Bn.
  - i <= i-1. When i==1, go to FINAL.
- FINAL: pt <= {B - S[1], A - S[0]}, err <= 0, go to DONE.
- DONE: out_valid=1 and pt is held stable until out_ready. Then go to IDLE with out_valid=0 on the next cycle.
- Arithmetic rules: all subtraction is modulo 2^W. Rotate amounts use the low log2(W)=4 bits. A rotate amount of 0 is an identity.
- Latency: accept at cycle 0; out_valid rises at cycle r+2 for r>=1, at cycle 2 for r=0, and at cycle 1 on error.
- Throughput: one block per r+3 cycles minimum, because IDLE is revisited between blocks.
- Abort: if key_ready falls while in ROUND or FINAL, go to IDLE immediately with no output and no err. A completed block in DONE is not affected by key_ready.
- in_valid while busy is ignored because in_ready=0. A ct change while not accepted has no effect.
- rst asserted mid-operation returns everything to the reset values on the next edge.
- num_rounds and sub are only read on accept and during ROUND/FINAL. The upstream block must hold sub stable while key_ready=1.

Decomposition:
- rc5_pkg: W, LGW=4, MAX_ROUNDS, T, P=16'hb7e1, Q=16'h9e37, word_t (logic [W-1:0]), block_t (logic [2W-1:0]), and the state enum.
- The key generator shares rc5_pkg.
- One sub-module: rc5_rotr, a combinational W-bit barrel rotate-right with an LGW-bit amount. Instantiate it twice, once per half-round.

Test Plan:
- All S=0, r=0, ct=0x1234_5678 -> pt=0x1234_5678, err=0, out_valid at cycle 2.
- S[0]=0x0001, S[1]=0x0002, rest 0, r=0, ct=0x0010_0005 -> pt=0x000E_0004.
- All S=0, r=1, ct=0x0000_0001 -> pt=0x0001_8001, out_valid at cycle 3.
- key_ready=0 with in_valid=1 -> in_ready=0 and no accept. Then r=12 with keygen subkeys and a model-encrypted random block -> pt matches the plaintext, out_valid at cycle 14. Run 500 random blocks with random out_ready backpressure and check pt holds stable while stalled.
- r=13 -> out_valid at cycle 1 with err=1, pt=0. Next block with r=12 decrypts correctly.
- Drop key_ready at cycle 5 of an r=12 block -> no out_valid, return to IDLE. Assert rst mid-ROUND -> all outputs return to reset values on the next edge.
